dm_readout: RTL and testbench

- Host-side reader for the processor's data memory.
- On the rising edge of end_process it takes ownership of the data-memory read port and walks a programmed address window.
- Each word is streamed out on a valid/ready interface toward a host link (UART or debug bridge).
- The processor writes results into data memory; dm_readout reads them out after the run.

---
 rtl/dm_readout_pkg.sv | 21 ++
 rtl/dm_readout_rise_detect.sv | 26 ++
 rtl/dm_readout.sv | 193 +++++++++++++++++++
 tb/tb_dm_readout.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_readout_pkg.sv
// Shared types and constants for the data-memory readout block.
// Holds the readout FSM state encoding, default data-memory widths and the
// address tag carried by the optional checksum beat.
package dm_readout_pkg;

  // Default widths match the processor's data memory.
  localparam int DM_ADDR_W = 12;
  localparam int DM_DATA_W = 12;

  // Address tag of the checksum beat; truncated to ADDR_W bits it is all ones.
  localparam logic [31:0] CHECKSUM_ADDR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    FIN
  } state_t;

endpackage

// File: rtl/dm_readout_rise_detect.sv
// Purpose: registered rising-edge detector for a level input (e.g. end_process).
// Latency: rise is combinational from d against the previous registered sample.
// Backpressure: none; one-cycle pulse per 0->1 transition.
// Ports: clk, rst (async active-high), d (level in), rise (pulse out).
// A level already high when reset releases reads as a rise on the first clock,
// because the stored sample is cleared by reset.
module dm_readout_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/dm_readout.sv
// Purpose: after a processor run, walk a data-memory window and stream each word to a host link.
// Latency: first beat valid READ_LAT+1 clocks after the start edge; READ_LAT+2 clocks per word.
// Backpressure: a beat is held stable in HOLD until out_ready; nothing is issued meanwhile.
// Ports: clk, rst (async active-high); end_process (rising edge starts a dump);
//   mem_req/mem_addr/mem_rdata (data-memory read port, mem_req selects the top-level mux);
//   out_valid/out_ready/out_data/out_addr/out_last (beat stream); busy, done (one-cycle pulse).
// Optional: define DM_READOUT_CHECKSUM_EN to append a modulo-2^DATA_W sum beat
//   tagged with an all-ones address; out_last then marks that beat.
module dm_readout
  import dm_readout_pkg::*;
#(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int START_ADDR = 0,
  parameter int WORD_COUNT = 16,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              end_process,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
  // Index of the final data word; WORD_COUNT==0 never reaches WAIT so 0 is harmless.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((WORD_COUNT == 0) ? 0 : WORD_COUNT - 1);
  localparam logic [2:0]        LAT      = 3'(READ_LAT);
  localparam bit                EMPTY    = (WORD_COUNT == 0);

  logic              start;
  state_t            state_q;
  state_t            state_d;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] word_cnt;

`ifdef DM_READOUT_CHECKSUM_EN
  localparam logic [ADDR_W-1:0] CK_ADDR = CHECKSUM_ADDR[ADDR_W-1:0];
  logic [DATA_W-1:0] sum;
  // Beat currently in HOLD is the final data word; the checksum beat follows it.
  logic              data_last;
`endif

  dm_readout_rise_detect u_start (
    .clk  (clk),
    .rst  (rst),
    .d    (end_process),
    .rise (start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // Starts arriving in any other state are dropped, not queued.
        if (start) begin
`ifdef DM_READOUT_CHECKSUM_EN
          state_d = EMPTY ? HOLD : ISSUE;
`else
          state_d = EMPTY ? FIN : ISSUE;
`endif
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (lat_cnt == 3'd1) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_last) begin
            state_d = FIN;
          end
`ifdef DM_READOUT_CHECKSUM_EN
          else if (data_last) begin
            state_d = HOLD;
          end
`endif
          else begin
            state_d = ISSUE;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= START;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
`ifdef DM_READOUT_CHECKSUM_EN
      sum       <= '0;
      data_last <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mem_addr <= START;
            word_cnt <= '0;
`ifdef DM_READOUT_CHECKSUM_EN
            sum      <= '0;
            // Empty window: the checksum beat of 0 is the whole dump.
            if (EMPTY) begin
              out_data  <= '0;
              out_addr  <= CK_ADDR;
              out_last  <= 1'b1;
              data_last <= 1'b0;
            end
`endif
          end
        end
        ISSUE: lat_cnt <= LAT;
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          // mem_addr has been stable since ISSUE, so it tags the captured word.
          if (lat_cnt == 3'd1) begin
            out_data <= mem_rdata;
            out_addr <= mem_addr;
`ifdef DM_READOUT_CHECKSUM_EN
            sum       <= sum + mem_rdata;
            data_last <= (word_cnt == LAST_IDX);
            out_last  <= 1'b0;
`else
            out_last  <= (word_cnt == LAST_IDX);
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (out_last) begin
              out_last <= 1'b0;
            end
`ifdef DM_READOUT_CHECKSUM_EN
            else if (data_last) begin
              out_data  <= sum;
              out_addr  <= CK_ADDR;
              out_last  <= 1'b1;
              data_last <= 1'b0;
            end
`endif
            else begin
              // Address wraps modulo 2^ADDR_W by natural overflow.
              word_cnt <= word_cnt + 1'b1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_readout.sv
// Bench for dm_readout: a default instance (START 0, 16 words, READ_LAT 1) and a
// wrapping instance (START 4094, 4 words, READ_LAT 3), each with its own memory.
`timescale 1ns/1ps
module tb_dm_readout;

`ifdef DM_READOUT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int M_START = 0;
  localparam int M_WC    = 16;
  localparam int M_RL    = 1;
  localparam int W_START = 4094;
  localparam int W_WC    = 4;
  localparam int W_RL    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ep_m = 1'b0, rdy_m = 1'b0;
  logic        m_req, m_valid, m_last, m_busy, m_done;
  logic [11:0] m_addr, m_rdata, m_data, m_oaddr;
  logic        ep_w = 1'b0, rdy_w = 1'b0;
  logic        w_req, w_valid, w_last, w_busy, w_done;
  logic [11:0] w_addr, w_rdata, w_data, w_oaddr;
  logic [11:0] w_p1, w_p2;

  logic [11:0] mem_m [4096];
  logic [11:0] mem_w [4096];

  dm_readout #(.ADDR_W(12), .DATA_W(12), .START_ADDR(M_START), .WORD_COUNT(M_WC), .READ_LAT(M_RL)) u_main (
    .clk(clk), .rst(rst), .end_process(ep_m), .mem_req(m_req), .mem_addr(m_addr), .mem_rdata(m_rdata),
    .out_valid(m_valid), .out_ready(rdy_m), .out_data(m_data), .out_addr(m_oaddr), .out_last(m_last),
    .busy(m_busy), .done(m_done));

  dm_readout #(.ADDR_W(12), .DATA_W(12), .START_ADDR(W_START), .WORD_COUNT(W_WC), .READ_LAT(W_RL)) u_wrap (
    .clk(clk), .rst(rst), .end_process(ep_w), .mem_req(w_req), .mem_addr(w_addr), .mem_rdata(w_rdata),
    .out_valid(w_valid), .out_ready(rdy_w), .out_data(w_data), .out_addr(w_oaddr), .out_last(w_last),
    .busy(w_busy), .done(w_done));

  // Synchronous memories with 1 and 3 cycles of read latency.
  always @(posedge clk) m_rdata <= mem_m[m_addr];
  always @(posedge clk) begin
    w_p1    <= mem_w[w_addr];
    w_p2    <= w_p1;
    w_rdata <= w_p2;
  end

  // Selected-instance view used by the dump monitor.
  bit          sel = 1'b0;
  logic        o_req, o_valid, o_last, o_busy, o_done;
  logic [11:0] o_data, o_addr;
  always_comb begin
    if (sel) begin
      o_req = w_req; o_valid = w_valid; o_last = w_last; o_busy = w_busy; o_done = w_done;
      o_data = w_data; o_addr = w_oaddr;
    end else begin
      o_req = m_req; o_valid = m_valid; o_last = m_last; o_busy = m_busy; o_done = m_done;
      o_data = m_data; o_addr = m_oaddr;
    end
  end

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic [3:0] pat;
    int         off;
    bit         pulse;
    int         exp_beats;
    int         exp_d0;
    int         exp_dlast;
    int         exp_v0;
  } vec_t;

  beat_t obs[$];
  beat_t exp_q[$];
  int    starts[$];
  int    n_done, stab_err, busy_err;
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [11:0] wrap_addrs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic set_ep(input bit which, input logic v);
    if (which) ep_w = v;
    else ep_m = v;
  endtask

  task automatic set_rdy(input bit which, input logic v);
    if (which) rdy_w = v;
    else rdy_m = v;
  endtask

  // Expected beat list straight from the rules: consecutive addresses modulo 4096,
  // last flag on the final word, optional trailing sum beat tagged 0xFFF.
  task automatic build_exp(input bit which);
    int st, wc, a;
    int unsigned s;
    beat_t b;
    st = which ? W_START : M_START;
    wc = which ? W_WC : M_WC;
    exp_q.delete();
    s = 0;
    for (int k = 0; k < wc; k++) begin
      a   = (st + k) % 4096;
      b.a = a[11:0];
      b.d = which ? mem_w[a] : mem_m[a];
      b.l = (k == wc - 1) && !CK;
      s  += b.d;
      exp_q.push_back(b);
    end
    if (CK) begin
      b.a = 12'hFFF;
      b.d = 12'(s % 4096);
      b.l = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Start a dump with a rising end_process, drive out_ready from a cyclic 4-bit
  // pattern, and record accepted beats, beat start cycles, stalls and done pulses.
  // Cycle 1 is the first falling edge after the start edge.
  task automatic run_dump(input bit which, input logic [3:0] pat, input bit pulse_again);
    int    cyc, post;
    bit    prev_v, prev_acc, r;
    beat_t prev_b, cur;
    sel = which;
    obs.delete();
    starts.delete();
    n_done = 0; stab_err = 0; busy_err = 0;
    post = 0; prev_v = 1'b0; prev_acc = 1'b0; prev_b = '0;
    set_ep(which, 1'b1);
    @(negedge clk);
    cyc = 1;
    while (cyc <= 600 && post < 4) begin
      if (cyc == 3) set_ep(which, 1'b0);
      if (pulse_again && cyc == 10) set_ep(which, 1'b1);
      if (pulse_again && cyc == 12) set_ep(which, 1'b0);
      r = pat[cyc % 4];
      set_rdy(which, r);
      cur.a = o_addr; cur.d = o_data; cur.l = o_last;
      if (prev_v && !prev_acc && (!o_valid || cur != prev_b)) stab_err++;
      if (o_valid && (!prev_v || prev_acc)) starts.push_back(cyc);
      if (o_valid && r) obs.push_back(cur);
      if (o_valid && !o_busy) busy_err++;
      if (o_req !== o_busy) busy_err++;
      if (o_done) begin
        n_done++;
        if (o_busy) busy_err++;
      end
      if (n_done > 0) post++;
      prev_v = o_valid; prev_acc = o_valid && r; prev_b = cur;
      @(negedge clk);
      cyc++;
    end
    set_rdy(which, 1'b0);
    set_ep(which, 1'b0);
  endtask

  task automatic compare_dump(input string tag, input int rl, input int wc, input bit timing);
    int n, terr;
    check({tag, "_beat_count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d{addr,data,last}", tag, i), obs[i], exp_q[i]);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_stall_unstable"}, stab_err, 0);
    check({tag, "_busy_req_errs"}, busy_err, 0);
    if (timing) begin
      terr = (starts.size() < wc) ? 1 : 0;
      for (int k = 0; k < wc && k < starts.size(); k++)
        if (starts[k] != 2 + rl + k * (rl + 2)) terr++;
      check({tag, "_beat_timing_errs"}, terr, 0);
    end
  endtask

  task automatic check_main_reset(input string tag);
    check(tag, {m_req, m_valid, m_last, m_busy, m_done, m_addr, m_data, m_oaddr}, 41'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   act;
    bit   found;
    logic [3:0] rp;

    // Hand-computed vectors for the default instance (addresses 0..15, data = (addr+off) mod 4096).
    vecs[0] = '{4'b1111, 100, 1'b0, 16 + int'(CK), 100, 115, 3};
    vecs[1] = '{4'b1001, 200, 1'b0, 16 + int'(CK), 200, 215, 3};
    vecs[2] = '{4'b0101,   7, 1'b1, 16 + int'(CK),   7,  22, 3};
    vecs[3] = '{4'b1111, 4090, 1'b1, 16 + int'(CK), 4090,  9, 3};
    wrap_addrs = '{12'd4094, 12'd4095, 12'd0, 12'd1};

    repeat (3) @(negedge clk);
    check_main_reset("reset_main_outputs");
    check("reset_wrap_mem_addr", w_addr, 12'd4094);
    check("reset_wrap_outputs", {w_req, w_valid, w_last, w_busy, w_done, w_data, w_oaddr}, 29'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int a = 0; a < 4096; a++) mem_m[a] = 12'((a + vecs[v].off) % 4096);
      build_exp(1'b0);
      run_dump(1'b0, vecs[v].pat, vecs[v].pulse);
      compare_dump($sformatf("vec%0d", v), M_RL, M_WC, vecs[v].pat == 4'b1111);
      check($sformatf("vec%0d_beats", v), obs.size(), vecs[v].exp_beats);
      act = (obs.size() > 0) ? int'(obs[0].d) : -1;
      check($sformatf("vec%0d_first_data", v), act, vecs[v].exp_d0);
      act = (obs.size() > M_WC - 1) ? int'(obs[M_WC - 1].d) : -1;
      check($sformatf("vec%0d_last_data", v), act, vecs[v].exp_dlast);
      act = (starts.size() > 0) ? starts[0] : -1;
      check($sformatf("vec%0d_first_valid_cycle", v), act, vecs[v].exp_v0);
    end

    // Reset while beat 5 sits in HOLD: immediate reset values, then a clean restart.
    for (int a = 0; a < 4096; a++) mem_m[a] = 12'((a + 100) % 4096);
    sel = 1'b0;
    ep_m = 1'b1;
    rdy_m = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (m_valid && m_oaddr == 12'd5) found = 1'b1;
    end
    check("abort_reached_beat5", found, 1'b1);
    rdy_m = 1'b0;
    rst = 1'b1;
    #1;
    check_main_reset("abort_outputs_same_cycle");
    @(negedge clk);
    check_main_reset("abort_outputs_held");
    rst = 1'b0;
    // end_process is still high, so the first clock after reset is a start.
    build_exp(1'b0);
    run_dump(1'b0, 4'b1111, 1'b0);
    compare_dump("restart", M_RL, M_WC, 1'b1);

    // Wrapping window on the long-latency instance.
    for (int a = 0; a < 4096; a++) mem_w[a] = 12'($urandom);
    build_exp(1'b1);
    run_dump(1'b1, 4'b1111, 1'b0);
    compare_dump("wrap", W_RL, W_WC, 1'b1);
    for (int k = 0; k < 4; k++) begin
      act = (obs.size() > k) ? int'(obs[k].a) : -1;
      check($sformatf("wrap_addr%0d", k), act, wrap_addrs[k]);
    end

    // Data 1, 2, 3, 4095 across the wrap.
    mem_w[4094] = 12'd1; mem_w[4095] = 12'd2; mem_w[0] = 12'd3; mem_w[1] = 12'd4095;
    build_exp(1'b1);
    run_dump(1'b1, 4'b1011, 1'b0);
    compare_dump("sumdata", W_RL, W_WC, 1'b0);
`ifdef DM_READOUT_CHECKSUM_EN
    // 1 + 2 + 3 + 4095 = 4101, which is 5 modulo 4096.
    act = (obs.size() > 4) ? int'(obs[4].d) : -1;
    check("checksum_data", act, 5);
    act = (obs.size() > 4) ? int'(obs[4].a) : -1;
    check("checksum_addr", act, 4095);
    act = (obs.size() > 4) ? int'(obs[4].l) : -1;
    check("checksum_last", act, 1);
    act = (obs.size() > 3) ? int'(obs[3].l) : -1;
    check("checksum_data_beat3_not_last", act, 0);
`else
    check("sumdata_beats", obs.size(), 4);
    act = (obs.size() > 3) ? int'(obs[3].l) : -1;
    check("sumdata_beat3_last", act, 1);
`endif

    // Randomized contents, ready patterns and stray start pulses.
    for (int it = 0; it < 8; it++) begin
      bit w;
      w  = (it % 3 == 2);
      rp = 4'($urandom_range(1, 15));
      for (int a = 0; a < 4096; a++) begin
        mem_m[a] = 12'($urandom);
        mem_w[a] = 12'($urandom);
      end
      build_exp(w);
      run_dump(w, rp, 1'($urandom_range(0, 1)));
      compare_dump($sformatf("rand%0d", it), w ? W_RL : M_RL, w ? W_WC : M_WC, rp == 4'b1111);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
